// File: rtl/key_conditioner_if.sv
// Key-side bundle: raw active-low buttons in, conditioned active-high events out.
interface key_conditioner_if #(
  parameter int N_KEYS = 2
);
  logic [N_KEYS-1:0] KEY;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_repeat;

  modport master (
    output KEY,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_repeat
  );

  modport slave (
    input  KEY,
    output key_level,
    output key_press,
    output key_release,
    output key_repeat
  );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchronizer, debounce FSM and auto-repeat timer for the DE10-Lite push buttons.
// Every output is a flop; nothing combinational reaches the ports from KEY.
module key_conditioner #(
  parameter int N_KEYS          = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic            MAX10_CLK1_50,
  input  logic            RESET,
  key_conditioner_if.slave io
);

  localparam int DBW     = $clog2(DEBOUNCE_CYCLES);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPW     = $clog2(REP_MAX + 1);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DBW-1:0] DB_ONE    = DBW'(1);
  localparam logic [RPW-1:0] REP_FIRST = RPW'(REPEAT_DELAY);
  localparam logic [RPW-1:0] REP_NEXT  = RPW'(REPEAT_RATE);

  // Encoding puts key_level in bit 1 so level is a pure state flop.
  typedef enum logic [1:0] {
    S_IDLE         = 2'b00,
    S_PRESS_WAIT   = 2'b01,
    S_HELD         = 2'b10,
    S_RELEASE_WAIT = 2'b11
  } state_t;

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] w_level;
  logic [N_KEYS-1:0] w_press;
  logic [N_KEYS-1:0] w_release;
  logic [N_KEYS-1:0] w_repeat;

  always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
    if (RESET) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~io.KEY;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < N_KEYS; g++) begin : g_key
    state_t         r_state;
    state_t         w_next;
    logic [DBW-1:0] r_db_cnt;
    logic [RPW-1:0] r_rep_cnt;
    logic           r_rep_armed;
    logic           r_press;
    logic           r_release;
    logic           r_repeat;
    logic           w_ks;
    logic           w_db_done;
    logic           w_lvl;
    logic           w_press_evt;
    logic           w_release_evt;
    logic           w_rep_hit;

    assign w_ks      = r_sync2[g];
    assign w_db_done = (r_db_cnt == DB_LAST);

    always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_next;
    end

    always_comb begin
      w_next = r_state;
      case (r_state)
        S_IDLE:         if (w_ks) w_next = S_PRESS_WAIT;
        S_PRESS_WAIT:   if (!w_ks) w_next = S_IDLE;
                        else if (w_db_done) w_next = S_HELD;
        S_HELD:         if (!w_ks) w_next = S_RELEASE_WAIT;
        S_RELEASE_WAIT: if (w_ks) w_next = S_HELD;
                        else if (w_db_done) w_next = S_IDLE;
        default:        w_next = S_IDLE;
      endcase
    end

    always_comb begin
      w_lvl         = (r_state == S_HELD) || (r_state == S_RELEASE_WAIT);
      w_press_evt   = (r_state == S_PRESS_WAIT) && (w_next == S_HELD);
      w_release_evt = (r_state == S_RELEASE_WAIT) && (w_next == S_IDLE);
    end

    always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
      if (RESET) begin
        r_db_cnt  <= '0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE:         r_db_cnt <= w_ks ? DB_ONE : '0;
          S_PRESS_WAIT:   r_db_cnt <= (!w_ks || w_db_done) ? '0 : r_db_cnt + 1'b1;
          S_HELD:         r_db_cnt <= w_ks ? '0 : DB_ONE;
          S_RELEASE_WAIT: r_db_cnt <= (w_ks || w_db_done) ? '0 : r_db_cnt + 1'b1;
          default:        r_db_cnt <= '0;
        endcase
        r_press   <= w_press_evt;
        r_release <= w_release_evt;
      end
    end

    // Bounces through RELEASE_WAIT keep level high, so the repeat phase survives them.
    assign w_rep_hit = ((r_rep_cnt + 1'b1) == (r_rep_armed ? REP_NEXT : REP_FIRST));

    always_ff @(posedge MAX10_CLK1_50 or posedge RESET) begin
      if (RESET) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b0;
        r_repeat    <= 1'b0;
      end else if (REPEAT_DELAY == 0 || !w_lvl || w_release_evt) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b0;
        r_repeat    <= 1'b0;
      end else if (w_rep_hit) begin
        r_rep_cnt   <= '0;
        r_rep_armed <= 1'b1;
        r_repeat    <= 1'b1;
      end else begin
        r_rep_cnt   <= r_rep_cnt + 1'b1;
        r_repeat    <= 1'b0;
      end
    end

    assign w_level[g]   = w_lvl;
    assign w_press[g]   = r_press;
    assign w_release[g] = r_release;
    assign w_repeat[g]  = r_repeat;
  end

  assign io.key_level   = w_level;
  assign io.key_press   = w_press;
  assign io.key_release = w_release;
  assign io.key_repeat  = w_repeat;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
module tb_key_conditioner;
  localparam int NK = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  key_conditioner_if #(.N_KEYS(NK)) kif ();

  key_conditioner #(
    .N_KEYS(NK), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut (
    .MAX10_CLK1_50(clk),
    .RESET        (rst),
    .io           (kif.slave)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic bounce [7];
    bounce = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    kif.KEY = 2'b11;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_level",   kif.key_level,   2'b00);
    chk("rst_press",   kif.key_press,   2'b00);
    chk("rst_release", kif.key_release, 2'b00);
    chk("rst_repeat",  kif.key_repeat,  2'b00);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // clean press of key 0, early release before any repeat
    kif.KEY[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("t1_press",  kif.key_press,  (k == 6) ? 2'b01 : 2'b00);
      chk("t1_level",  kif.key_level,  (k >= 6) ? 2'b01 : 2'b00);
      if (k == 7) kif.KEY[0] = 1'b1;
    end
    for (int k = 8; k <= 15; k++) begin
      @(negedge clk);
      chk("t1_release", kif.key_release, (k == 13) ? 2'b01 : 2'b00);
      chk("t1_level2",  kif.key_level,   (k < 13) ? 2'b01 : 2'b00);
      chk("t1_repeat",  kif.key_repeat,  2'b00);
    end

    // bounce rejection
    for (int k = 0; k < 7; k++) begin
      kif.KEY[0] = bounce[k];
      @(negedge clk);
      chk("t2_bounce_press", kif.key_press, 2'b00);
      chk("t2_bounce_level", kif.key_level, 2'b00);
    end
    kif.KEY[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t2_press", kif.key_press, (k == 6) ? 2'b01 : 2'b00);
    end

    // auto-repeat, release timed onto a would-be repeat slot
    for (int j = 1; j <= 45; j++) begin
      @(negedge clk);
      chk("t3_repeat",  kif.key_repeat[0],
          (j < 37 && j >= 10 && (j - 10) % 3 == 0) ? 1'b1 : 1'b0);
      chk("t3_release", kif.key_release, (j == 37) ? 2'b01 : 2'b00);
      chk("t3_level",   kif.key_level,   (j < 37) ? 2'b01 : 2'b00);
      chk("t3_press",   kif.key_press,   2'b00);
      if (j == 31) kif.KEY[0] = 1'b1;
    end

    // release glitch while held
    kif.KEY[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t4_press", kif.key_press, (k == 6) ? 2'b01 : 2'b00);
    end
    for (int j = 1; j <= 30; j++) begin
      @(negedge clk);
      chk("t4_level",   kif.key_level,   (j < 26) ? 2'b01 : 2'b00);
      chk("t4_release", kif.key_release, (j == 26) ? 2'b01 : 2'b00);
      chk("t4_repeat",  kif.key_repeat[0],
          (j < 26 && j >= 10 && (j - 10) % 3 == 0) ? 1'b1 : 1'b0);
      if (j == 5)  kif.KEY[0] = 1'b1;
      if (j == 7)  kif.KEY[0] = 1'b0;
      if (j == 20) kif.KEY[0] = 1'b1;
    end

    // independence: both keys together, release only key 1
    kif.KEY = 2'b00;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t5_press", kif.key_press, (k == 6) ? 2'b11 : 2'b00);
    end
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      chk("t5_release", kif.key_release, (j == 8) ? 2'b10 : 2'b00);
      chk("t5_level",   kif.key_level,   (j < 8) ? 2'b11 : 2'b01);
      chk("t5_press2",  kif.key_press,   2'b00);
      if (j == 2) kif.KEY[1] = 1'b1;
    end

    // reset mid-hold of key 0
    @(negedge clk);
    chk("t6_pre_level", kif.key_level, 2'b01);
    rst = 1'b1;
    #1;
    chk("t6_async_level",   kif.key_level,   2'b00);
    chk("t6_async_press",   kif.key_press,   2'b00);
    chk("t6_async_release", kif.key_release, 2'b00);
    chk("t6_async_repeat",  kif.key_repeat,  2'b00);
    repeat (2) @(negedge clk);
    chk("t6_hold_level", kif.key_level, 2'b00);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("t6_press",   kif.key_press,   (k == 6) ? 2'b01 : 2'b00);
      chk("t6_level",   kif.key_level,   (k >= 6) ? 2'b01 : 2'b00);
      chk("t6_release", kif.key_release, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input-side companion to the board-level state logic: takes the raw, active-low DE10-Lite push buttons and delivers clean, synchronous, active-high key events to the FSMs that drive LEDR and HEX. Each key passes through a two-flop synchronizer and a debounce FSM. The block then emits a debounced level, single-cycle press and release pulses, and auto-repeat pulses while the key is held. One instance sits between the KEY pins and all consumer logic in the top level.

## Interface
- N_KEYS, 2, number of keys conditioned (1..8)
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a change (10 ms at 50 MHz); legal range ≥ 2
- REPEAT_DELAY, 25000000, cycles from press pulse to first repeat pulse (500 ms); 0 disables repeat
- REPEAT_RATE, 5000000, cycles between subsequent repeat pulses (100 ms); legal range ≥ 1

- MAX10_CLK1_50  in  1  sole clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- KEY  in  N_KEYS  raw push buttons, active-low (0 = pressed), asynchronous to clock
- key_level  out  N_KEYS  debounced state, 1 = pressed
- key_press  out  N_KEYS  one-cycle pulse when key_level rises
- key_release  out  N_KEYS  one-cycle pulse when key_level falls
- key_repeat  out  N_KEYS  one-cycle pulse per auto-repeat interval while held

## Operation
- Keys are fully independent; per key i:
  - Synchronizer: two flops on ~KEY[i] give k_s[i].
  - Debounce counter: width $clog2(DEBOUNCE_CYCLES).
- Per-key FSM states:
  - IDLE: key_level=0.
  - PRESS_WAIT: key_level=0, counting.
  - HELD: key_level=1.
  - RELEASE_WAIT: key_level=1, counting.
- Transitions:
  - IDLE→PRESS_WAIT when k_s=1; counter loads 1.
  - PRESS_WAIT: k_s=0 → IDLE, counter cleared (glitch rejected). k_s=1 with counter=DEBOUNCE_CYCLES-1 → HELD, key_level←1, key_press pulses. Otherwise the counter increments.
  - HELD→RELEASE_WAIT when k_s=0. RELEASE_WAIT mirrors PRESS_WAIT: a bounce back to k_s=1 returns to HELD without pulsing. A full count goes to IDLE, key_level←0, key_release pulses.
- Auto-repeat, per key, repeat counter width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1):
  - Cleared on the key_press cycle.
  - Counts in HELD and RELEASE_WAIT.
  - Pulses key_repeat when the count reaches REPEAT_DELAY, then every REPEAT_RATE cycles after that.
  - Cleared on entry to IDLE.
  - A bounce into RELEASE_WAIT does not restart the repeat timing.
- key_press, key_release and key_repeat are mutually exclusive per key in any cycle. key_press/key_release are exactly one cycle wide.
- A key held through RESET deassertion is treated as a fresh press: key_press is reported after the debounce interval.
- All outputs are registered; no combinational path from KEY to any output.

## Timing
- Reset values: key_level=0, key_press=0, key_release=0, key_repeat=0, all FSMs IDLE, all counters 0, synchronizer flops 0.
- Reset is asynchronous assert. Deassertion is taken as already synchronous to MAX10_CLK1_50.
- Press latency: KEY[i] falls and stays low. First sampling edge is E0. k_s=1 after E1, FSM enters PRESS_WAIT at E2. key_level and key_press assert after edge E2+DEBOUNCE_CYCLES-1, i.e. DEBOUNCE_CYCLES+1 edges after E0.
- Release latency is identical, measured from KEY[i] rising.
- Any low pulse on KEY shorter than DEBOUNCE_CYCLES cycles produces no output activity.
- Repeat: with key_press at cycle P:
  - First key_repeat at P+REPEAT_DELAY.
  - Then at P+REPEAT_DELAY+n·REPEAT_RATE.
  - No key_repeat in or after the key_release cycle.
- RESET asserted mid-debounce or mid-hold: outputs drop to 0 immediately. No key_release pulse is generated.

## Test plan
Simulation parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, N_KEYS=2.

- Clean press: KEY[0] 1→0 and held → key_level[0] rises and key_press[0] pulses exactly once, 5 edges after first low sample. KEY[1] outputs remain 0.
- Bounce rejection: KEY[0] toggles low 2 cycles, high 1, low 3, high 1, then stable low → no pulse during bouncing. key_press appears once, 5 edges after the final stable low.
- Auto-repeat: hold KEY[0] for 30 cycles after key_press at P → key_repeat pulses at P+10, P+13, P+16, …. Release → key_release once, then no further repeats.
- Release glitch: while HELD, KEY[0] high for 2 cycles then low → key_level stays 1, no key_release. Repeat cadence continues unchanged.
- Independence: press KEY[0] and KEY[1] on the same cycle → both key_press bits pulse on the same cycle. Release only KEY[1] → only key_release[1].
- Reset mid-hold: RESET asserted while key_level[0]=1 → all outputs 0 asynchronously, no key_release. Deassert with KEY[0] still low → key_press[0] after 5 edges.
